pipe_clock_ctrl: RTL and testbench

Parametrised pipeline clock-enable controller that replaces the fixed PLL-output divider in front of the 5-stage processor. It synchronises PLL lock, divides the PLL clock by a runtime-programmable ratio, and issues single-cycle stage-advance ticks in run, halt, single-step or burst mode. It sits between the PLL and the Fetch/Decode/Execute/Memory/Writeback stages. It also drives a legacy divided clock for stages not yet converted to clock enables.

---
 rtl/pipe_clock_ctrl_pkg.sv | 30 +++
 rtl/pipe_clock_ctrl_lock_sync.sv | 27 ++
 rtl/pipe_clock_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_clock_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_clock_ctrl_pkg.sv
// Shared encodings for the pipeline clock-enable controller: mode inputs,
// FSM states and the mode-to-state decode.
package pipe_clock_ctrl_pkg;

   localparam logic [1:0] MODE_RUN   = 2'b00;
   localparam logic [1:0] MODE_HALT  = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic [2:0] {
      ST_UNLOCK = 3'd0,
      ST_RUN    = 3'd1,
      ST_HALT   = 3'd2,
      ST_STEP   = 3'd3,
      ST_BURST  = 3'd4
   } state_e;

   function automatic state_e mode_to_state(input logic [1:0] mode);
      state_e st;
      st = ST_HALT;
      case (mode)
         MODE_RUN:   st = ST_RUN;
         MODE_STEP:  st = ST_STEP;
         MODE_BURST: st = ST_BURST;
         default:    st = ST_HALT;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/pipe_clock_ctrl_lock_sync.sv
// Two-flop synchroniser for an asynchronous level. sync_next_o is the value
// sync_o takes on the next edge, so consumers can act in step with it.
module pipe_clock_ctrl_lock_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o,
   output logic sync_next_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o      = sync_q;
   assign sync_next_o = meta_q;

endmodule

// File: rtl/pipe_clock_ctrl.sv
// Pipeline clock-enable controller: PLL lock sync, programmable divider and
// RUN/HALT/STEP/BURST tick gating, plus a legacy divided clock and tick counter.
module pipe_clock_ctrl
   import pipe_clock_ctrl_pkg::*;
#(
   parameter int unsigned DIV_WIDTH    = 32,
   parameter int unsigned BURST_WIDTH  = 16,
   parameter int unsigned TCOUNT_WIDTH = 32
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET_N,
   input  logic                    I_PLL_LOCKED,
   input  logic [DIV_WIDTH-1:0]    I_DIV,
   input  logic [1:0]              I_MODE,
   input  logic                    I_STEP,
   input  logic [BURST_WIDTH-1:0]  I_BURST_LEN,
   output logic                    O_LOCK,
   output logic                    O_TICK,
   output logic                    O_SLOW_CLK,
   output logic                    O_BUSY,
   output logic [TCOUNT_WIDTH-1:0] O_TICK_COUNT,
   output state_e                  O_STATE
);

   logic                    lock_q;
   logic                    lock_next;
   logic                    run;
   logic                    term;
   logic                    step_rise;
   logic                    mode_change;
   logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
   state_e                  state_q, state_d;
   logic                    step_q, step_prev_q;
   logic                    pending_q, pending_d;
   logic [BURST_WIDTH-1:0]  rem_q, rem_d;
   logic                    tick_q, tick_d;
   logic                    busy_q, busy_d;
   logic                    slow_q;
   logic [TCOUNT_WIDTH-1:0] count_q;

   pipe_clock_ctrl_lock_sync u_lock_sync (
      .clk_i       (I_CLOCK),
      .rst_ni      (I_RESET_N),
      .async_i     (I_PLL_LOCKED),
      .sync_o      (lock_q),
      .sync_next_o (lock_next)
   );

   // Gating on both the current and next lock keeps the divider at 0, and
   // suppresses ticks, in every cycle whose outputs show O_LOCK low.
   always_comb begin
      run       = lock_q & lock_next;
      term      = run && (cnt_q >= I_DIV);
      step_rise = step_q & ~step_prev_q;

      cnt_d = '0;
      if (run && !term) cnt_d = cnt_q + DIV_WIDTH'(1);

      if (!lock_next)                state_d = ST_UNLOCK;
      else if (state_q == ST_UNLOCK) state_d = ST_HALT;
      else                           state_d = mode_to_state(I_MODE);
      mode_change = (state_d != state_q);

      case (state_q)
         ST_RUN:   tick_d = term;
         ST_STEP:  tick_d = term & pending_q;
         ST_BURST: tick_d = term & (rem_q != '0);
         default:  tick_d = 1'b0;
      endcase

      pending_d = pending_q;
      rem_d     = rem_q;
      if (state_q == ST_STEP) begin
         if (tick_d)         pending_d = 1'b0;
         else if (step_rise) pending_d = 1'b1;
      end
      if (state_q == ST_BURST) begin
         if (step_rise)   rem_d = I_BURST_LEN;
         else if (tick_d) rem_d = rem_q - BURST_WIDTH'(1);
      end
      // Any mode change or lock loss aborts an in-flight step or burst.
      if (!run || mode_change) begin
         pending_d = 1'b0;
         rem_d     = '0;
      end

      busy_d = pending_d | (rem_d != '0);
   end

   always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         cnt_q       <= '0;
         state_q     <= ST_UNLOCK;
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
         pending_q   <= 1'b0;
         rem_q       <= '0;
         tick_q      <= 1'b0;
         busy_q      <= 1'b0;
         slow_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         step_q      <= I_STEP;
         step_prev_q <= step_q;
         pending_q   <= pending_d;
         rem_q       <= rem_d;
         tick_q      <= tick_d;
         busy_q      <= busy_d;
         slow_q      <= slow_q ^ tick_d;
         count_q     <= count_q + TCOUNT_WIDTH'(tick_d);
      end
   end

   assign O_LOCK       = lock_q;
   assign O_TICK       = tick_q;
   assign O_SLOW_CLK   = slow_q;
   assign O_BUSY       = busy_q;
   assign O_TICK_COUNT = count_q;
   assign O_STATE      = state_q;

endmodule

// File: tb/tb_pipe_clock_ctrl.sv
// Directed bench for pipe_clock_ctrl: lock sync, divider, step/burst gating,
// lock loss, async reset and tick-counter wrap (narrow second instance).
`timescale 1ns/1ps
module tb_pipe_clock_ctrl;
   import pipe_clock_ctrl_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, wrap_rst_n;
   logic        pll_locked;
   logic [31:0] div;
   logic [1:0]  mode;
   logic        step;
   logic [15:0] burst_len;

   logic        lock, tick, slow, busy;
   logic [31:0] tick_count;
   state_e      state;

   logic        w_lock, w_tick, w_slow, w_busy;
   logic [2:0]  w_count;
   state_e      w_state;

   pipe_clock_ctrl u_dut (
      .I_CLOCK      (clk),
      .I_RESET_N    (rst_n),
      .I_PLL_LOCKED (pll_locked),
      .I_DIV        (div),
      .I_MODE       (mode),
      .I_STEP       (step),
      .I_BURST_LEN  (burst_len),
      .O_LOCK       (lock),
      .O_TICK       (tick),
      .O_SLOW_CLK   (slow),
      .O_BUSY       (busy),
      .O_TICK_COUNT (tick_count),
      .O_STATE      (state)
   );

   pipe_clock_ctrl #(.TCOUNT_WIDTH(3)) u_wrap (
      .I_CLOCK      (clk),
      .I_RESET_N    (wrap_rst_n),
      .I_PLL_LOCKED (1'b1),
      .I_DIV        (32'd0),
      .I_MODE       (MODE_RUN),
      .I_STEP       (1'b0),
      .I_BURST_LEN  (16'd0),
      .O_LOCK       (w_lock),
      .O_TICK       (w_tick),
      .O_SLOW_CLK   (w_slow),
      .O_BUSY       (w_busy),
      .O_TICK_COUNT (w_count),
      .O_STATE      (w_state)
   );

   // ---------------- scoreboard ----------------
   int          total = 0;
   int          bad   = 0;
   logic        slow_exp  = 1'b0;
   logic [31:0] count_exp = '0;
   logic        exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bit i of pat is the expected O_TICK after the (i+1)-th edge from now.
   // Slow clock and tick count expectations follow from the tick pattern.
   task automatic expect_ticks(input string tag, input int n, input logic [63:0] pat);
      logic e;
      for (int i = 0; i < n; i++) exp_q.push_back(pat[i]);
      for (int i = 0; i < n; i++) begin
         cyc(1);
         e = exp_q.pop_front();
         if (e) begin
            slow_exp  = ~slow_exp;
            count_exp = count_exp + 32'd1;
         end
         check_val({tag, "_tick"}, tick, e);
         check_val({tag, "_slow"}, slow, slow_exp);
         check_val({tag, "_count"}, tick_count, count_exp);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic found;
      rst_n      = 1'b0;
      wrap_rst_n = 1'b0;
      pll_locked = 1'b1;
      div        = 32'd1;
      mode       = MODE_RUN;
      step       = 1'b0;
      burst_len  = 16'd0;
      cyc(3);
      check_val("rst_lock", lock, 0);
      check_val("rst_tick", tick, 0);
      check_val("rst_slow", slow, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_count", tick_count, 0);
      check_val("rst_state", state, ST_UNLOCK);
      rst_n = 1'b1;

      // T1: RUN, div 1 -> lock on 2nd edge, tick every 2 cycles
      cyc(1);
      check_val("t1_lock_e1", lock, 0);
      check_val("t1_state_e1", state, ST_UNLOCK);
      cyc(1);
      check_val("t1_lock_e2", lock, 1);
      check_val("t1_state_e2", state, ST_HALT);
      expect_ticks("t1_run", 11, 64'h2AA);
      check_val("t1_state_run", state, ST_RUN);

      // T2: div 4, shrink to 1 while cnt = 3 -> terminates next cycle
      div = 32'd4;
      expect_ticks("t2_div4", 2, 64'h0);
      div = 32'd1;
      expect_ticks("t2_shrink", 3, 64'h5);

      // T3: STEP, div 3, two pulses -> exactly one tick
      mode = MODE_STEP;
      div  = 32'd3;
      expect_ticks("t3_idle", 3, 64'h0);
      step = 1'b1;
      expect_ticks("t3_e4", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t3_e5", 1, 64'h0);
      check_val("t3_busy_e5", busy, 1);
      step = 1'b1;
      expect_ticks("t3_e6", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t3_e7", 1, 64'h0);
      check_val("t3_busy_e7", busy, 1);
      expect_ticks("t3_e8", 1, 64'h1);
      check_val("t3_busy_e8", busy, 0);
      expect_ticks("t3_after", 8, 64'h0);

      // T4: BURST len 5, div 0 -> five back-to-back ticks; len 0 -> none
      mode      = MODE_BURST;
      div       = 32'd0;
      burst_len = 16'd5;
      expect_ticks("t4_e1", 1, 64'h0);
      step = 1'b1;
      expect_ticks("t4_e2", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t4_e3", 1, 64'h0);
      check_val("t4_busy_start", busy, 1);
      expect_ticks("t4_burst", 5, 64'h1F);
      check_val("t4_busy_end", busy, 0);
      expect_ticks("t4_quiet", 6, 64'h0);
      burst_len = 16'd0;
      step      = 1'b1;
      expect_ticks("t4_len0_a", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t4_len0_b", 9, 64'h0);
      check_val("t4_len0_busy", busy, 0);

      // T5: burst aborted by HALT with 3 remaining; back to BURST gives none
      div       = 32'd1;
      burst_len = 16'd5;
      step      = 1'b1;
      expect_ticks("t5_e1", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t5_burst", 5, 64'h14);
      check_val("t5_busy_mid", busy, 1);
      mode = MODE_HALT;
      expect_ticks("t5_halt", 1, 64'h0);
      check_val("t5_busy_halt", busy, 0);
      check_val("t5_state_halt", state, ST_HALT);
      expect_ticks("t5_halt_b", 3, 64'h0);
      mode = MODE_BURST;
      expect_ticks("t5_reburst", 8, 64'h0);
      check_val("t5_state_burst", state, ST_BURST);

      // T6: RUN div 0, lock loss mid-run, then relock into HALT
      mode = MODE_RUN;
      div  = 32'd0;
      expect_ticks("t6_run", 4, 64'hE);
      pll_locked = 1'b0;
      expect_ticks("t6_drop_e1", 1, 64'h1);
      check_val("t6_lock_e1", lock, 1);
      expect_ticks("t6_drop_e2", 1, 64'h0);
      check_val("t6_lock_e2", lock, 0);
      check_val("t6_state_unlock", state, ST_UNLOCK);
      check_val("t6_busy", busy, 0);
      expect_ticks("t6_unlocked", 4, 64'h0);
      pll_locked = 1'b1;
      expect_ticks("t6_relock_e1", 1, 64'h0);
      check_val("t6_relock_lock_e1", lock, 0);
      expect_ticks("t6_relock_e2", 1, 64'h0);
      check_val("t6_relock_lock_e2", lock, 1);
      check_val("t6_relock_state", state, ST_HALT);

      // T7: async reset mid-burst clears all outputs at once
      mode      = MODE_BURST;
      burst_len = 16'd10;
      step      = 1'b1;
      expect_ticks("t7_e1", 1, 64'h0);
      step = 1'b0;
      expect_ticks("t7_e2", 1, 64'h0);
      expect_ticks("t7_burst", 3, 64'h7);
      check_val("t7_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      slow_exp  = 1'b0;
      count_exp = '0;
      check_val("t7_rst_lock", lock, 0);
      check_val("t7_rst_tick", tick, 0);
      check_val("t7_rst_slow", slow, slow_exp);
      check_val("t7_rst_busy", busy, 0);
      check_val("t7_rst_count", tick_count, count_exp);
      check_val("t7_rst_state", state, ST_UNLOCK);

      // T8: 3-bit tick counter wraps from all-ones to 0
      wrap_rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cyc(1);
         found = (w_count == 3'd7);
      end
      check_val("t8_reach_max", found, 1);
      cyc(1);
      check_val("t8_wrap_count", w_count, 0);
      check_val("t8_wrap_tick", w_tick, 1);
      check_val("t8_wrap_slow", w_slow, 0);
      check_val("t8_wrap_lock", w_lock, 1);
      check_val("t8_wrap_busy", w_busy, 0);
      check_val("t8_wrap_state", w_state, ST_RUN);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
